// File: rtl/set_job_scheduler.sv
// set_job_scheduler
//   Accepts SET jobs from two requesters through a round-robin arbiter into a
//   small FIFO. Jobs are issued one at a time to a SET engine, and each result
//   is held for a consumer until accepted.
//
//   Optional feature macro: SET_SCHED_TIMEOUT_EN
//     When defined, a WAIT watchdog of TIMEOUT_CYC cycles (counted from the
//     set_en cycle) forces a result of 8'hFF with res_err=1.
//     When undefined, WAIT waits indefinitely and res_err is tied to 0.
//
//   Ports
//     clk, rst                 clock (rising edge), asynchronous active-low reset
//     req_valid/req_ready[1:0] per-requester job handshake
//     req_central/radius/mode  per-requester job payload (24b / 12b / 2b)
//     set_en, set_central/radius/mode  one-cycle job start to the engine
//     set_busy, set_valid, set_candidate  engine status and result strobe
//     res_valid/res_ready      result handshake to the consumer
//     res_id, res_candidate, res_err   held result
//     fifo_count               queue occupancy
module set_job_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][23:0] req_central,
  input  logic [1:0][11:0] req_radius,
  input  logic [1:0][1:0]  req_mode,
  output logic             set_en,
  output logic [23:0]      set_central,
  output logic [11:0]      set_radius,
  output logic [1:0]       set_mode,
  input  logic             set_busy,
  input  logic             set_valid,
  input  logic [7:0]       set_candidate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [7:0]       res_candidate,
  output logic             res_err,
  output logic [4:0]       fifo_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  typedef struct packed {
    logic        id;
    logic [1:0]  mode;
    logic [11:0] radius;
    logic [23:0] central;
  } job_t;

  job_t          mem [FIFO_DEPTH];
  job_t          push_job;
  job_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count_d;
  logic          full;
  logic          rr_ptr;
  logic          busy_q;
  logic          cur_id;
  logic [1:0]    grant;
  logic          push;
  logic          pop;
  logic          wait_done;
  state_t        state_q;
  state_t        state_d;

  // Arbitration: ready looks only at the registered full flag, so a pop in
  // the same cycle never frees a slot for a push.
  always_comb begin
    grant[0] = !full && req_valid[0] && (!req_valid[1] || !rr_ptr);
    grant[1] = !full && req_valid[1] && (!req_valid[0] ||  rr_ptr);
    push_job.id      = grant[1];
    push_job.mode    = req_mode[grant[1]];
    push_job.radius  = req_radius[grant[1]];
    push_job.central = req_central[grant[1]];
  end

  // Gated by rst so ready reads 0 while reset is held.
  assign req_ready = grant & {2{rst}};
  assign push      = |grant;
  assign head      = mem[rd_ptr];
  assign count_d   = fifo_count + {4'd0, push} - {4'd0, pop};

  // The engine busy flag is registered before it gates issue, so a falling
  // busy (like a result acceptance) leads to set_en two cycles later.
  assign pop = (state_q == IDLE) && (fifo_count != 5'd0) && !busy_q && !res_valid;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_job;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      full       <= 1'b0;
      rr_ptr     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      busy_q     <= set_busy;
      fifo_count <= count_d;
      full       <= (count_d == 5'(FIFO_DEPTH));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      // Priority passes to the loser only when both were competing.
      if (push && (&req_valid)) rr_ptr <= ~grant[1];
    end
  end

`ifdef SET_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer;
  logic          timeout_hit;

  // Counts cycles since set_en: 0 in ISSUE, so hitting TIMEOUT_CYC-1 in WAIT
  // raises res_valid exactly TIMEOUT_CYC cycles after set_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   timer <= '0;
    else if (pop)                               timer <= '0;
    else if (state_q == ISSUE || state_q == WAIT) timer <= timer + TW'(1);
  end

  assign timeout_hit = (state_q == WAIT) && !set_valid && (timer == TW'(TIMEOUT_CYC - 1));
  assign wait_done   = set_valid || timeout_hit;
`else
  assign wait_done   = set_valid;
  assign res_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    set_en  = 1'b0;
    unique case (state_q)
      IDLE:  if (pop) state_d = ISSUE;
      ISSUE: begin
        set_en  = 1'b1;
        state_d = WAIT;
      end
      WAIT:  if (wait_done) state_d = HOLD;
      HOLD:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      cur_id        <= 1'b0;
      res_valid     <= 1'b0;
      res_id        <= 1'b0;
      res_candidate <= '0;
`ifdef SET_SCHED_TIMEOUT_EN
      res_err       <= 1'b0;
`endif
    end else begin
      // Job fields are visible only during the set_en cycle.
      if (pop) begin
        set_central <= head.central;
        set_radius  <= head.radius;
        set_mode    <= head.mode;
        cur_id      <= head.id;
      end else if (state_q == ISSUE) begin
        set_central <= '0;
        set_radius  <= '0;
        set_mode    <= '0;
      end

      if (state_q == WAIT && set_valid) begin
        res_valid     <= 1'b1;
        res_id        <= cur_id;
        res_candidate <= set_candidate;
`ifdef SET_SCHED_TIMEOUT_EN
        res_err       <= 1'b0;
      end else if (timeout_hit) begin
        res_valid     <= 1'b1;
        res_id        <= cur_id;
        res_candidate <= 8'hFF;
        res_err       <= 1'b1;
`endif
      end else if (state_q == HOLD && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
